// File: rtl/error_detector_pkg.sv
// Shared definitions for the SoC error aggregator: the severity codes, the
// status bit map, and small helpers used by the top and the priority selector.
package error_detector_pkg;

  localparam int NUM_ERR_SRC = 19;

  typedef enum logic [2:0] {
    SEV_NONE     = 3'b000,
    SEV_INFO     = 3'b001,
    SEV_MINOR    = 3'b010,
    SEV_MAJOR    = 3'b011,
    SEV_CRITICAL = 3'b100,
    SEV_FATAL    = 3'b101
  } sev_e;

  localparam logic [4:0] ERR_L1_SINGLE   = 5'd0;
  localparam logic [4:0] ERR_L1_DOUBLE   = 5'd1;
  localparam logic [4:0] ERR_L2_SINGLE   = 5'd2;
  localparam logic [4:0] ERR_L2_DOUBLE   = 5'd3;
  localparam logic [4:0] ERR_L3_SINGLE   = 5'd4;
  localparam logic [4:0] ERR_L3_DOUBLE   = 5'd5;
  localparam logic [4:0] ERR_MEM_SINGLE  = 5'd6;
  localparam logic [4:0] ERR_MEM_DOUBLE  = 5'd7;
  localparam logic [4:0] ERR_CORE_ARITH  = 5'd8;
  localparam logic [4:0] ERR_CORE_PIPE   = 5'd9;
  localparam logic [4:0] ERR_TPU_COMPUTE = 5'd10;
  localparam logic [4:0] ERR_TPU_OVF     = 5'd11;
  localparam logic [4:0] ERR_VPU_COMPUTE = 5'd12;
  localparam logic [4:0] ERR_VPU_OVF     = 5'd13;
  localparam logic [4:0] ERR_NOC_DEADLK  = 5'd14;
  localparam logic [4:0] ERR_NOC_TMO     = 5'd15;
  localparam logic [4:0] ERR_POWER       = 5'd16;
  localparam logic [4:0] ERR_THERMAL     = 5'd17;
  localparam logic [4:0] ERR_CLOCK       = 5'd18;

  // Fixed severity of each status bit; reserved indices report NONE.
  function automatic sev_e sev_of(input logic [4:0] idx);
    case (idx)
      ERR_L1_SINGLE, ERR_L2_SINGLE, ERR_L3_SINGLE, ERR_MEM_SINGLE,
      ERR_TPU_OVF, ERR_VPU_OVF:                        sev_of = SEV_MINOR;
      ERR_CORE_ARITH, ERR_TPU_COMPUTE, ERR_VPU_COMPUTE,
      ERR_NOC_TMO:                                     sev_of = SEV_MAJOR;
      ERR_CORE_PIPE, ERR_NOC_DEADLK, ERR_POWER,
      ERR_THERMAL:                                     sev_of = SEV_CRITICAL;
      ERR_L1_DOUBLE, ERR_L2_DOUBLE, ERR_L3_DOUBLE, ERR_MEM_DOUBLE,
      ERR_CLOCK:                                       sev_of = SEV_FATAL;
      default:                                         sev_of = SEV_NONE;
    endcase
  endfunction

  // Index of the lowest set bit of a (zero-padded) unit vector, 0 if none.
  function automatic logic [3:0] lowest_unit(input logic [15:0] v);
    lowest_unit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_unit = 4'(i);
    end
  endfunction

endpackage

// File: rtl/error_detector_priority_sel.sv
// Picks the highest-severity set bit of an error vector; among equal
// severities the lowest index wins. Used for both reporting and logging.
module error_priority_sel
  import error_detector_pkg::*;
(
  input  logic [NUM_ERR_SRC-1:0] vec,
  output logic [2:0]             max_sev,
  output logic [4:0]             sel_idx
);

  // Scan from the top down so an equal severity at a lower index replaces.
  always_comb begin
    max_sev = SEV_NONE;
    sel_idx = 5'd0;
    for (int i = NUM_ERR_SRC - 1; i >= 0; i--) begin
      if (vec[i] && (sev_of(5'(i)) >= max_sev)) begin
        max_sev = sev_of(5'(i));
        sel_idx = 5'(i);
      end
    end
  end

endmodule

// File: rtl/error_detector.sv
// Central SoC error aggregator: sticky status, severity summary, maskable
// interrupt and a one-cycle log record for every newly detected error.
module error_detector
  import error_detector_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_TPUS  = 2,
  parameter int NUM_VPUS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] l1_cache_single_error,
  input  logic [NUM_CORES-1:0] l1_cache_double_error,
  input  logic                 l2_cache_single_error,
  input  logic                 l2_cache_double_error,
  input  logic                 l3_cache_single_error,
  input  logic                 l3_cache_double_error,
  input  logic                 memory_single_error,
  input  logic                 memory_double_error,
  input  logic [NUM_CORES-1:0] core_arithmetic_error,
  input  logic [NUM_CORES-1:0] core_pipeline_error,
  input  logic [NUM_TPUS-1:0]  tpu_compute_error,
  input  logic [NUM_TPUS-1:0]  tpu_overflow_error,
  input  logic [NUM_VPUS-1:0]  vpu_compute_error,
  input  logic [NUM_VPUS-1:0]  vpu_overflow_error,
  input  logic                 noc_deadlock_error,
  input  logic                 noc_timeout_error,
  input  logic                 power_domain_error,
  input  logic                 thermal_error,
  input  logic                 clock_error,
  output logic                 error_interrupt,
  output logic [31:0]          error_status,
  output logic [31:0]          error_mask,
  output logic [7:0]           error_severity,
  output logic                 error_log_valid,
  output logic [63:0]          error_log_data,
  output logic [31:0]          error_timestamp,
  input  logic                 error_clear,
  input  logic [31:0]          error_mask_set,
  input  logic                 error_inject_enable,
  input  logic [4:0]           error_inject_type
);

  logic [NUM_ERR_SRC-1:0] status_q, status_d;
  logic [31:0]            mask_q, mask_d;
  logic                   log_valid_q, log_valid_d;
  logic [63:0]            log_data_q, log_data_d;
  logic [31:0]            tstamp_q, tstamp_d;
  logic [31:0]            cnt_q, cnt_d;

  logic [NUM_ERR_SRC-1:0] raw;
  logic [NUM_ERR_SRC-1:0] new_bits;
  logic                   multi_new;
  logic [2:0]             stat_sev, log_sev;
  logic [4:0]             stat_idx, log_idx;
  logic [3:0]             unit_idx;

  // Fold the source strobes and any software injection into one vector.
  always_comb begin
    raw                  = '0;
    raw[ERR_L1_SINGLE]   = |l1_cache_single_error;
    raw[ERR_L1_DOUBLE]   = |l1_cache_double_error;
    raw[ERR_L2_SINGLE]   = l2_cache_single_error;
    raw[ERR_L2_DOUBLE]   = l2_cache_double_error;
    raw[ERR_L3_SINGLE]   = l3_cache_single_error;
    raw[ERR_L3_DOUBLE]   = l3_cache_double_error;
    raw[ERR_MEM_SINGLE]  = memory_single_error;
    raw[ERR_MEM_DOUBLE]  = memory_double_error;
    raw[ERR_CORE_ARITH]  = |core_arithmetic_error;
    raw[ERR_CORE_PIPE]   = |core_pipeline_error;
    raw[ERR_TPU_COMPUTE] = |tpu_compute_error;
    raw[ERR_TPU_OVF]     = |tpu_overflow_error;
    raw[ERR_VPU_COMPUTE] = |vpu_compute_error;
    raw[ERR_VPU_OVF]     = |vpu_overflow_error;
    raw[ERR_NOC_DEADLK]  = noc_deadlock_error;
    raw[ERR_NOC_TMO]     = noc_timeout_error;
    raw[ERR_POWER]       = power_domain_error;
    raw[ERR_THERMAL]     = thermal_error;
    raw[ERR_CLOCK]       = clock_error;
    // Out-of-range injection types match no index and are dropped.
    for (int i = 0; i < NUM_ERR_SRC; i++) begin
      if (error_inject_enable && (error_inject_type == 5'(i))) raw[i] = 1'b1;
    end
  end

  // Bits already pending are not logged a second time.
  assign new_bits  = raw & ~status_q;
  assign multi_new = (new_bits & (new_bits - 1'b1)) != '0;

  error_priority_sel u_stat_sel (
    .vec     (status_q),
    .max_sev (stat_sev),
    .sel_idx (stat_idx)
  );

  error_priority_sel u_log_sel (
    .vec     (new_bits),
    .max_sev (log_sev),
    .sel_idx (log_idx)
  );

  // Report which unit raised a per-unit source; scalar sources report 0.
  always_comb begin
    case (log_idx)
      ERR_L1_SINGLE:   unit_idx = lowest_unit(16'(l1_cache_single_error));
      ERR_L1_DOUBLE:   unit_idx = lowest_unit(16'(l1_cache_double_error));
      ERR_CORE_ARITH:  unit_idx = lowest_unit(16'(core_arithmetic_error));
      ERR_CORE_PIPE:   unit_idx = lowest_unit(16'(core_pipeline_error));
      ERR_TPU_COMPUTE: unit_idx = lowest_unit(16'(tpu_compute_error));
      ERR_TPU_OVF:     unit_idx = lowest_unit(16'(tpu_overflow_error));
      ERR_VPU_COMPUTE: unit_idx = lowest_unit(16'(vpu_compute_error));
      ERR_VPU_OVF:     unit_idx = lowest_unit(16'(vpu_overflow_error));
      default:         unit_idx = 4'd0;
    endcase
  end

  // Next-state: sticky status (set beats clear), mask load, log capture.
  always_comb begin
    status_d    = (error_clear ? '0 : status_q) | raw;
    mask_d      = error_mask_set;
    cnt_d       = cnt_q + 32'd1;
    log_valid_d = |new_bits;
    log_data_d  = log_data_q;
    tstamp_d    = tstamp_q;
    if (|new_bits) begin
      log_data_d = {cnt_q, 8'h00, multi_new, log_idx, log_sev, 11'h000, unit_idx};
      tstamp_d   = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= '0;
      mask_q      <= 32'hFFFF_FFFF;
      log_valid_q <= 1'b0;
      log_data_q  <= '0;
      tstamp_q    <= '0;
      cnt_q       <= '0;
    end else begin
      status_q    <= status_d;
      mask_q      <= mask_d;
      log_valid_q <= log_valid_d;
      log_data_q  <= log_data_d;
      tstamp_q    <= tstamp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign error_status    = {{(32 - NUM_ERR_SRC){1'b0}}, status_q};
  assign error_mask      = mask_q;
  assign error_interrupt = |(error_status & ~mask_q);
  assign error_severity  = {5'($countones(status_q)), stat_sev};
  assign error_log_valid = log_valid_q;
  assign error_log_data  = log_data_q;
  assign error_timestamp = tstamp_q;

endmodule

// File: tb/tb_error_detector.sv
// Randomized bench for error_detector with a table-driven reference model.
module tb_error_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  l1s, l1d, c_ar, c_pp;
  logic [1:0]  t_cp, t_ov, v_cp, v_ov;
  logic        l2s, l2d, l3s, l3d, ms, md;
  logic        noc_dl, noc_to, pwr, thr, clkerr;
  logic        clr, inj_en;
  logic [4:0]  inj_type;
  logic [31:0] mask_set;

  logic        irq, log_valid;
  logic [31:0] status, mask, tstamp;
  logic [7:0]  sev;
  logic [63:0] log_data;

  always #5 clk = ~clk;

  error_detector #(.NUM_CORES(4), .NUM_TPUS(2), .NUM_VPUS(2)) dut (
    .clk(clk), .rst(rst),
    .l1_cache_single_error(l1s), .l1_cache_double_error(l1d),
    .l2_cache_single_error(l2s), .l2_cache_double_error(l2d),
    .l3_cache_single_error(l3s), .l3_cache_double_error(l3d),
    .memory_single_error(ms), .memory_double_error(md),
    .core_arithmetic_error(c_ar), .core_pipeline_error(c_pp),
    .tpu_compute_error(t_cp), .tpu_overflow_error(t_ov),
    .vpu_compute_error(v_cp), .vpu_overflow_error(v_ov),
    .noc_deadlock_error(noc_dl), .noc_timeout_error(noc_to),
    .power_domain_error(pwr), .thermal_error(thr), .clock_error(clkerr),
    .error_interrupt(irq), .error_status(status), .error_mask(mask),
    .error_severity(sev), .error_log_valid(log_valid), .error_log_data(log_data),
    .error_timestamp(tstamp), .error_clear(clr), .error_mask_set(mask_set),
    .error_inject_enable(inj_en), .error_inject_type(inj_type)
  );

  // Severity of each status bit, straight from the bit map.
  int sev_tab [19] = '{2, 5, 2, 5, 2, 5, 2, 5, 3, 4, 3, 2, 3, 2, 4, 3, 4, 4, 5};

  int n_cmp = 0;
  int n_mis = 0;

  logic [18:0] m_status;
  logic [31:0] m_mask, m_ts, m_tsout;
  logic        m_valid;
  logic [63:0] m_log;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] unit_vec(input int i);
    case (i)
      0:  return 16'(l1s);
      1:  return 16'(l1d);
      8:  return 16'(c_ar);
      9:  return 16'(c_pp);
      10: return 16'(t_cp);
      11: return 16'(t_ov);
      12: return 16'(v_cp);
      13: return 16'(v_ov);
      default: return 16'h0;
    endcase
  endfunction

  task automatic idle();
    {l1s, l1d, c_ar, c_pp} = '0;
    {t_cp, t_ov, v_cp, v_ov} = '0;
    {l2s, l2d, l3s, l3d, ms, md} = '0;
    {noc_dl, noc_to, pwr, thr, clkerr} = '0;
    clr = 1'b0; inj_en = 1'b0; inj_type = 5'd0;
  endtask

  // Called just after a negedge with inputs driven; predicts, clocks, checks.
  task automatic cycle();
    logic [18:0] raw, nb;
    logic [15:0] v;
    logic [3:0]  unit;
    int best, smax;
    logic [31:0] st32;
    raw = '0;
    raw[0] = |l1s;  raw[1] = |l1d;  raw[2] = l2s;  raw[3] = l2d;
    raw[4] = l3s;   raw[5] = l3d;   raw[6] = ms;   raw[7] = md;
    raw[8] = |c_ar; raw[9] = |c_pp; raw[10] = |t_cp; raw[11] = |t_ov;
    raw[12] = |v_cp; raw[13] = |v_ov; raw[14] = noc_dl; raw[15] = noc_to;
    raw[16] = pwr;  raw[17] = thr;  raw[18] = clkerr;
    for (int i = 0; i < 19; i++) if (inj_en && int'(inj_type) == i) raw[i] = 1'b1;
    nb = raw & ~m_status;
    best = -1;
    for (int i = 0; i < 19; i++)
      if (nb[i] && (best < 0 || sev_tab[i] > sev_tab[best])) best = i;
    @(posedge clk);
    #1;
    if (rst) begin
      m_status = '0; m_mask = 32'hFFFF_FFFF; m_valid = 1'b0;
      m_log = '0; m_ts = '0; m_tsout = '0;
    end else begin
      m_valid = (best >= 0);
      if (m_valid) begin
        v = unit_vec(best);
        unit = 4'd0;
        for (int u = 0; u < 16; u++) if (v[u]) begin unit = 4'(u); break; end
        m_log = {m_ts, 8'h00, ($countones(nb) > 1), 5'(best), 3'(sev_tab[best]), 11'h000, unit};
        m_tsout = m_ts;
      end
      m_status = (clr ? 19'h0 : m_status) | raw;
      m_mask = mask_set;
      m_ts = m_ts + 32'd1;
    end
    smax = 0;
    for (int i = 0; i < 19; i++) if (m_status[i] && sev_tab[i] > smax) smax = sev_tab[i];
    st32 = {13'h0, m_status};
    chk("status",    64'(status),    64'(st32));
    chk("mask",      64'(mask),      64'(m_mask));
    chk("interrupt", 64'(irq),       64'(|(st32 & ~m_mask)));
    chk("severity",  64'(sev),       64'({5'($countones(m_status)), 3'(smax)}));
    chk("log_valid", 64'(log_valid), 64'(m_valid));
    chk("log_data",  log_data,       m_log);
    chk("timestamp", 64'(tstamp),    64'(m_tsout));
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mask_set = 32'h0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_status", 64'(status), 64'h0);
    chk("rst_mask", 64'(mask), 64'hFFFF_FFFF);
    rst = 1'b0;

    // Single L1 error, unmasked.
    l1s = 4'b0001; cycle(); idle();
    chk("t1_bit0", 64'(status[0]), 64'd1);
    chk("t1_irq", 64'(irq), 64'd1);
    chk("t1_sev", 64'(sev[2:0]), 64'd2);
    chk("t1_type", 64'(log_data[22:18]), 64'd0);

    // Fully masked: status sets, interrupt stays low.
    mask_set = 32'hFFFF_FFFF; cycle();
    l2s = 1'b1; cycle(); idle();
    chk("t2_bit2", 64'(status[2]), 64'd1);
    chk("t2_irq", 64'(irq), 64'd0);

    // Simultaneous single + double.
    clr = 1'b1; cycle(); idle();
    l1s = 4'b0010; l1d = 4'b1000; cycle(); idle();
    chk("t3_sev", 64'(sev[2:0]), 64'd5);
    chk("t3_type", 64'(log_data[22:18]), 64'd1);
    chk("t3_multi", 64'(log_data[23]), 64'd1);
    chk("t3_unit", 64'(log_data[3:0]), 64'd3);

    // Core arithmetic on core 2, then held: only one log.
    clr = 1'b1; cycle(); idle();
    c_ar = 4'b0100; cycle();
    chk("t4_valid", 64'(log_valid), 64'd1);
    chk("t4_type", 64'(log_data[22:18]), 64'd8);
    chk("t4_sev", 64'(log_data[17:15]), 64'd3);
    chk("t4_unit", 64'(log_data[3:0]), 64'd2);
    cycle(); idle();
    chk("t4_nolog", 64'(log_valid), 64'd0);

    // Injection in range and out of range.
    clr = 1'b1; cycle(); idle();
    inj_en = 1'b1; inj_type = 5'd10; cycle(); idle();
    chk("t5_inj10", 64'(status), 64'h400);
    inj_en = 1'b1; inj_type = 5'd25; cycle(); idle();
    chk("t5_inj25", 64'(status), 64'h400);

    // Clear with a simultaneous set, then clear alone.
    mask_set = 32'h0;
    clr = 1'b1; clkerr = 1'b1; cycle(); idle();
    chk("t6_status", 64'(status), 64'h4_0000);
    chk("t6_sev", 64'(sev[2:0]), 64'd5);
    clr = 1'b1; cycle(); idle();
    chk("t6_clr", 64'(status), 64'h0);
    chk("t6_irq", 64'(irq), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      idle();
      if ($urandom_range(0, 11) == 0) l1s = 4'($urandom);
      if ($urandom_range(0, 11) == 0) l1d = 4'($urandom);
      if ($urandom_range(0, 11) == 0) c_ar = 4'($urandom);
      if ($urandom_range(0, 11) == 0) c_pp = 4'($urandom);
      if ($urandom_range(0, 11) == 0) t_cp = 2'($urandom);
      if ($urandom_range(0, 11) == 0) t_ov = 2'($urandom);
      if ($urandom_range(0, 11) == 0) v_cp = 2'($urandom);
      if ($urandom_range(0, 11) == 0) v_ov = 2'($urandom);
      l2s = ($urandom_range(0, 11) == 0); l2d = ($urandom_range(0, 11) == 0);
      l3s = ($urandom_range(0, 11) == 0); l3d = ($urandom_range(0, 11) == 0);
      ms  = ($urandom_range(0, 11) == 0); md  = ($urandom_range(0, 11) == 0);
      noc_dl = ($urandom_range(0, 11) == 0); noc_to = ($urandom_range(0, 11) == 0);
      pwr = ($urandom_range(0, 11) == 0); thr = ($urandom_range(0, 11) == 0);
      clkerr = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 5) == 0);
      inj_en = ($urandom_range(0, 5) == 0);
      inj_type = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: mask_set = 32'h0;
        1: mask_set = 32'hFFFF_FFFF;
        default: mask_set = $urandom;
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
